// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : Registered ALU for the Pink accumulator processor. Computes
//               arithmetic, logic, shift and signed-compare results with a
//               one-cycle latency, plus a branch-decision flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_unit #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] InputA,
    input  logic [WIDTH-1:0] InputB,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] ALUOut,
    output logic             ShouldBranch
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_SLL  = 4'b0010;
    localparam logic [3:0] c_OP_SRL  = 4'b0011;
    localparam logic [3:0] c_OP_SLT  = 4'b0100;
    localparam logic [3:0] c_OP_OR   = 4'b0101;
    localparam logic [3:0] c_OP_AND  = 4'b0110;
    localparam logic [3:0] c_OP_XOR  = 4'b0111;
    localparam logic [3:0] c_OP_EQ   = 4'b1000;
    localparam logic [3:0] c_OP_NE   = 4'b1001;
    localparam logic [3:0] c_OP_LT   = 4'b1010;
    localparam logic [3:0] c_OP_GE   = 4'b1011;
    localparam logic [3:0] c_OP_GT   = 4'b1101;
    localparam logic [3:0] c_OP_LE   = 4'b1110;

    logic             w_eq;
    logic             w_lt;
    logic [3:0]       w_shamt;
    logic             w_cond;
    logic             w_branch;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_out;
    logic             r_branch;

    assign w_eq    = (InputA == InputB);
    assign w_lt    = ($signed(InputA) < $signed(InputB));
    assign w_shamt = InputB[3:0];

    always_comb begin
        w_result = '0;
        w_cond   = 1'b0;
        w_branch = 1'b0;
        case (ALUOp)
            c_OP_ADD: w_result = InputA + InputB;
            c_OP_SUB: w_result = InputA - InputB;
            c_OP_SLL: w_result = InputA << w_shamt;
            c_OP_SRL: w_result = InputA >> w_shamt;
            c_OP_SLT: w_cond   = w_lt;
            c_OP_OR:  w_result = InputA | InputB;
            c_OP_AND: w_result = InputA & InputB;
            c_OP_XOR: w_result = InputA ^ InputB;
            c_OP_EQ:  begin w_cond = w_eq;            w_branch = 1'b1; end
            c_OP_NE:  begin w_cond = !w_eq;           w_branch = 1'b1; end
            c_OP_LT:  begin w_cond = w_lt;            w_branch = 1'b1; end
            c_OP_GE:  begin w_cond = !w_lt;           w_branch = 1'b1; end
            c_OP_GT:  begin w_cond = !w_lt && !w_eq;  w_branch = 1'b1; end
            c_OP_LE:  begin w_cond = w_lt || w_eq;    w_branch = 1'b1; end
            default:  w_result = '0;
        endcase
        // SLT reports through the result only; branch compares drive both.
        if (ALUOp == c_OP_SLT || w_branch) begin
            w_result = {{(WIDTH-1){1'b0}}, w_cond};
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_out    <= '0;
            r_branch <= 1'b0;
        end else begin
            r_out    <= w_result;
            r_branch <= w_branch & w_cond;
        end
    end

    assign ALUOut       = r_out;
    assign ShouldBranch = r_branch;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Scoreboard bench for alu_unit; directed plan cases followed by
//               randomized operations checked against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] InputA = '0;
    logic [15:0] InputB = '0;
    logic [3:0]  ALUOp = '0;
    logic [15:0] ALUOut;
    logic        ShouldBranch;

    typedef struct {
        logic [15:0] out;
        logic        br;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_unit #(.WIDTH(16)) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .InputA       (InputA),
        .InputB       (InputB),
        .ALUOp        (ALUOp),
        .ALUOut       (ALUOut),
        .ShouldBranch (ShouldBranch)
    );

    always #5 CLK = ~CLK;

    // Monitor: each rising edge produces exactly one result for the inputs
    // presented during the preceding cycle.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (ALUOut !== e.out || ShouldBranch !== e.br) begin
                failures++;
                $display("FAIL %s: got out=%h br=%b, expected out=%h br=%b",
                         e.name, ALUOut, ShouldBranch, e.out, e.br);
            end
        end
    end

    function automatic int to_signed(input int unsigned v);
        return (v >= 32768) ? int'(v) - 65536 : int'(v);
    endfunction

    function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] op,
                                  output logic [15:0] o, output logic br);
        int unsigned ua = a;
        int unsigned ub = b;
        int          sa = to_signed(a);
        int          sb = to_signed(b);
        int unsigned r  = 0;
        bit          is_cmp = 1'b0;
        bit          cond   = 1'b0;
        case (op)
            4'd0:  r = (ua + ub) % 65536;
            4'd1:  r = (ua + 65536 - ub) % 65536;
            4'd2:  r = (ua * (32'd1 << (ub % 16))) % 65536;
            4'd3:  r = ua / (32'd1 << (ub % 16));
            4'd4:  begin is_cmp = 1; cond = (sa < sb); end
            4'd5:  r = ua | ub;
            4'd6:  r = ua & ub;
            4'd7:  r = ua ^ ub;
            4'd8:  begin is_cmp = 1; cond = (ua == ub); end
            4'd9:  begin is_cmp = 1; cond = (ua != ub); end
            4'd10: begin is_cmp = 1; cond = (sa < sb); end
            4'd11: begin is_cmp = 1; cond = (sa >= sb); end
            4'd13: begin is_cmp = 1; cond = (sa > sb); end
            4'd14: begin is_cmp = 1; cond = (sa <= sb); end
            default: r = 0;
        endcase
        if (is_cmp) r = cond ? 1 : 0;
        o  = 16'(r);
        br = (op >= 8 && op <= 14 && op != 12) ? cond : 1'b0;
    endfunction

    task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] op, input logic [15:0] eo, input logic eb,
                        input string nm);
        @(negedge CLK);
        Reset  = rst;
        InputA = a;
        InputB = b;
        ALUOp  = op;
        q.push_back('{eo, eb, nm});
    endtask

    task automatic stepm(input logic rst, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input string nm);
        logic [15:0] eo;
        logic        eb;
        model(a, b, op, eo, eb);
        if (rst) begin
            eo = '0;
            eb = 1'b0;
        end
        step(rst, a, b, op, eo, eb, nm);
    endtask

    int unsigned sweep_out[15] = '{2, 0, 2, 0, 0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1};

    initial begin
        // Reset priority over a live ADD
        step(1'b1, 16'h1234, 16'h0001, 4'd0, 16'h0000, 1'b0, "reset0");
        step(1'b1, 16'h1234, 16'h0001, 4'd0, 16'h0000, 1'b0, "reset1");
        step(1'b0, 16'h1234, 16'h0001, 4'd0, 16'h1235, 1'b0, "first_add");

        for (int i = 0; i < 15; i++) begin
            step(1'b0, 16'h0001, 16'h0001, 4'(i), 16'(sweep_out[i]),
                 (i == 8 || i == 11 || i == 14), $sformatf("sweep_op%0d", i));
        end

        step(1'b0, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 1'b0, "add_wrap");
        step(1'b0, 16'h0000, 16'h0001, 4'd1, 16'hFFFF, 1'b0, "sub_wrap");
        step(1'b0, 16'h0001, 16'h0013, 4'd2, 16'h0008, 1'b0, "sll_lowbits");
        step(1'b0, 16'h8000, 16'h000F, 4'd3, 16'h0001, 1'b0, "srl_15");

        step(1'b0, 16'h8000, 16'h0001, 4'd10, 16'h0001, 1'b1, "lt_neg");
        step(1'b0, 16'h8000, 16'h0001, 4'd11, 16'h0000, 1'b0, "ge_neg");
        step(1'b0, 16'h8000, 16'h0001, 4'd4,  16'h0001, 1'b0, "slt_neg");
        step(1'b0, 16'h7FFF, 16'hFFFF, 4'd13, 16'h0001, 1'b1, "gt_pos");
        step(1'b0, 16'h7FFF, 16'h8000, 4'd14, 16'h0000, 1'b0, "le_extreme");

        step(1'b0, 16'h00F0, 16'h0F0F, 4'd0, 16'h0FFF, 1'b0, "b2b_add");
        step(1'b0, 16'h00F0, 16'h0F0F, 4'd7, 16'h0FFF, 1'b0, "b2b_xor");
        step(1'b0, 16'h00F0, 16'h0F0F, 4'd8, 16'h0000, 1'b0, "b2b_eq");
        step(1'b0, 16'h1234, 16'h1234, 4'd12, 16'h0000, 1'b0, "rsvd_12");
        step(1'b0, 16'hFFFF, 16'hFFFF, 4'd15, 16'h0000, 1'b0, "rsvd_15");

        // Mid-stream reset discards the in-flight result
        step(1'b0, 16'h0005, 16'h0006, 4'd0, 16'h000B, 1'b0, "pre_reset_add");
        step(1'b1, 16'h0009, 16'h0009, 4'd8, 16'h0000, 1'b0, "mid_reset");
        step(1'b0, 16'h0003, 16'h0004, 4'd0, 16'h0007, 1'b0, "post_reset_add");

        for (int i = 0; i < 400; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            logic [3:0]  op;
            logic        rst;
            a   = 16'($urandom);
            b   = 16'($urandom);
            op  = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 24) == 0);
            // Bias toward equal and boundary operands to hit compare edges
            case ($urandom_range(0, 7))
                0: b = a;
                1: a = 16'h8000;
                2: b = 16'h7FFF;
                default: ;
            endcase
            stepm(rst, a, b, op, $sformatf("rand%0d_op%0d", i, op));
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge CLK);
        #3;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
